// File: rtl/pool_relu_ctrl_pkg.sv
// Shared definitions for the pooling/ReLU controller: data width, default address width, FSM encoding.
package pool_relu_ctrl_pkg;

    localparam int unsigned DATSIZE = 22;
    localparam int unsigned AW_DEF  = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD0  = 3'd1,
        ST_RD1  = 3'd2,
        ST_RD2  = 3'd3,
        ST_RD3  = 3'd4,
        ST_CAP  = 3'd5,
        ST_WR   = 3'd6,
        ST_DONE = 3'd7
    } state_e;

endpackage

// File: rtl/max_4.sv
// Signed maximum of four values (purely combinational).
module max_4
    import pool_relu_ctrl_pkg::*;
(
    input  logic [DATSIZE-1:0] a,
    input  logic [DATSIZE-1:0] b,
    input  logic [DATSIZE-1:0] c,
    input  logic [DATSIZE-1:0] d,
    output logic [DATSIZE-1:0] max_c
);

    logic [DATSIZE-1:0] m_ab;
    logic [DATSIZE-1:0] m_cd;

    // Two-level signed compare tree.
    always_comb begin
        m_ab  = ($signed(a) > $signed(b)) ? a : b;
        m_cd  = ($signed(c) > $signed(d)) ? c : d;
        max_c = ($signed(m_ab) > $signed(m_cd)) ? m_ab : m_cd;
    end

endmodule

// File: rtl/relu.sv
// ReLU: negative inputs clamp to zero (purely combinational).
module relu
    import pool_relu_ctrl_pkg::*;
(
    input  logic [DATSIZE-1:0] din,
    output logic [DATSIZE-1:0] dout_c
);

    // Sign bit selects zero.
    always_comb begin
        dout_c = din[DATSIZE-1] ? '0 : din;
    end

endmodule

// File: rtl/pool_relu_ctrl.sv
// 2x2 max-pool controller with optional ReLU: walks every window of every channel,
// reads four pixels, writes one pooled pixel with a ready/valid style write port.
module pool_relu_ctrl
    import pool_relu_ctrl_pkg::*;
#(
    parameter int unsigned FM_W = 24,
    parameter int unsigned FM_H = 24,
    parameter int unsigned NCH  = 4,
    parameter int unsigned AW   = AW_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               relu_en,
    output logic               busy,
    output logic               done,
    output logic               rd_en,
    output logic [AW-1:0]      rd_addr,
    input  logic [DATSIZE-1:0] rd_data,
    output logic               wr_en,
    output logic [AW-1:0]      wr_addr,
    output logic [DATSIZE-1:0] wr_data,
    input  logic               wr_ready
);

    localparam int unsigned CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned R_W   = (FM_H > 2) ? $clog2(FM_H) : 1;
    localparam int unsigned C_W   = (FM_W > 2) ? $clog2(FM_W) : 1;
    localparam int unsigned OUT_W = FM_W / 2;
    localparam int unsigned OUT_H = FM_H / 2;

    state_e state_q, state_d;

    logic [CH_W-1:0]    ch_q, ch_d;
    logic [R_W-1:0]     r_q, r_d;
    logic [C_W-1:0]     c_q, c_d;
    logic [DATSIZE-1:0] win_q [4];
    logic [DATSIZE-1:0] win_d [4];
    logic               relu_q, relu_d;

    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               rd_en_q, rd_en_d;
    logic [AW-1:0]      rd_addr_q, rd_addr_d;
    logic               wr_en_q, wr_en_d;
    logic [AW-1:0]      wr_addr_q, wr_addr_d;
    logic [DATSIZE-1:0] wr_data_q, wr_data_d;

    logic               last_win_c;
    logic [DATSIZE-1:0] max_c;
    logic [DATSIZE-1:0] relu_c;
    logic [DATSIZE-1:0] pool_c;
    logic [31:0]        in_base;
    logic [31:0]        rd_off;
    logic [31:0]        out_base;

    assign last_win_c = (ch_q == CH_W'(NCH - 1)) && (r_q == R_W'(FM_H - 2)) && (c_q == C_W'(FM_W - 2));

    // The fourth window value is taken from the capture path so the result is ready on entry to WR.
    max_4 u_max_4 (
        .a     (win_q[0]),
        .b     (win_q[1]),
        .c     (win_q[2]),
        .d     (win_d[3]),
        .max_c (max_c)
    );

    relu u_relu (
        .din    (max_c),
        .dout_c (relu_c)
    );

    assign pool_c = relu_q ? relu_c : max_c;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start only matters in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RD0;
            ST_RD0:  state_d = ST_RD1;
            ST_RD1:  state_d = ST_RD2;
            ST_RD2:  state_d = ST_RD3;
            ST_RD3:  state_d = ST_CAP;
            ST_CAP:  state_d = ST_WR;
            ST_WR:   if (wr_ready) state_d = last_win_c ? ST_DONE : ST_RD0;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Window position counters, window capture and relu_en latch.
    always_comb begin
        ch_d   = ch_q;
        r_d    = r_q;
        c_d    = c_q;
        win_d  = win_q;
        relu_d = relu_q;
        if (state_q == ST_IDLE && start) begin
            relu_d = relu_en;
        end
        case (state_q)
            ST_RD1:  win_d[0] = rd_data;
            ST_RD2:  win_d[1] = rd_data;
            ST_RD3:  win_d[2] = rd_data;
            ST_CAP:  win_d[3] = rd_data;
            default: ;
        endcase
        if (state_q == ST_WR && wr_ready) begin
            if (c_q == C_W'(FM_W - 2)) begin
                c_d = '0;
                if (r_q == R_W'(FM_H - 2)) begin
                    r_d  = '0;
                    ch_d = (ch_q == CH_W'(NCH - 1)) ? '0 : ch_q + CH_W'(1);
                end else begin
                    r_d = r_q + R_W'(2);
                end
            end else begin
                c_d = c_q + C_W'(2);
            end
        end
    end

    // Outputs decoded from the next state so the registered outputs line up with the state.
    always_comb begin
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_DONE);
        wr_en_d = (state_d == ST_WR);
        rd_en_d = 1'b0;
        rd_off  = '0;
        case (state_d)
            ST_RD0:  begin rd_en_d = 1'b1; rd_off = '0;         end
            ST_RD1:  begin rd_en_d = 1'b1; rd_off = 32'd1;      end
            ST_RD2:  begin rd_en_d = 1'b1; rd_off = FM_W;       end
            ST_RD3:  begin rd_en_d = 1'b1; rd_off = FM_W + 1;   end
            default: ;
        endcase
        in_base   = 32'(ch_d) * (FM_H * FM_W) + 32'(r_d) * FM_W + 32'(c_d);
        out_base  = 32'(ch_d) * (OUT_H * OUT_W) + 32'(r_d >> 1) * OUT_W + 32'(c_d >> 1);
        rd_addr_d = rd_en_d ? AW'(in_base + rd_off) : rd_addr_q;
        wr_addr_d = wr_en_d ? AW'(out_base) : wr_addr_q;
        wr_data_d = (state_q == ST_CAP) ? pool_c : wr_data_q;
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ch_q      <= '0;
            r_q       <= '0;
            c_q       <= '0;
            win_q     <= '{default: '0};
            relu_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            ch_q      <= ch_d;
            r_q       <= r_d;
            c_q       <= c_d;
            win_q     <= win_d;
            relu_q    <= relu_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rd_en   = rd_en_q;
    assign rd_addr = rd_addr_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

endmodule

// File: tb/tb_pool_relu_ctrl.sv
// Bench for pool_relu_ctrl on a 4x4 map with two channels: read/write scoreboards
// plus a table of window values and hand-written stall / restart / reset sequences.
module tb_pool_relu_ctrl;

    localparam int unsigned DW  = 22;
    localparam int unsigned AWT = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic           relu_en = 1'b0;
    logic           wr_ready = 1'b1;
    logic           busy, done, rd_en, wr_en;
    logic [AWT-1:0] rd_addr, wr_addr;
    logic [DW-1:0]  rd_data = '0;
    logic [DW-1:0]  wr_data;

    typedef struct {
        int addr;
        int data;
    } wexp_t;

    typedef struct {
        logic relu;
        int   w0;
        int   w1;
        int   w2;
        int   w3;
        int   exp;
    } vec_t;

    wexp_t wq[$];
    int    rq[$];
    int    fix[$];
    int    obs_rd[$];
    int    obs_wr[$];
    int    img[32];
    vec_t  vecs[11];
    wexp_t wcur;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int done_cnt = 0;
    bit hold_prev = 1'b0;
    int prev_addr = 0;
    int prev_data = 0;

    pool_relu_ctrl #(
        .FM_W (4),
        .FM_H (4),
        .NCH  (2),
        .AW   (AWT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .relu_en  (relu_en),
        .busy     (busy),
        .done     (done),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_ready (wr_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Input buffer: data one cycle after the read strobe.
    always @(posedge clk) rd_data <= rd_en ? DW'(img[rd_addr[4:0]]) : '0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int pool(input int b, input logic relu);
        int m;
        m = img[b];
        if (img[b + 1] > m) m = img[b + 1];
        if (img[b + 4] > m) m = img[b + 4];
        if (img[b + 5] > m) m = img[b + 5];
        if (relu && m < 0) m = 0;
        return m;
    endfunction

    task automatic set_base();
        for (int i = 0; i < 16; i++) begin
            img[i]      = i;
            img[16 + i] = ((i * 7) % 11) - 5;
        end
    endtask

    // Expected read addresses and writes for one full run; leading writes may be fixed constants.
    task automatic load_exp(input logic relu);
        int k;
        int b;
        int e;
        k = 0;
        wq.delete();
        rq.delete();
        for (int ch = 0; ch < 2; ch++) begin
            for (int r = 0; r < 4; r += 2) begin
                for (int c = 0; c < 4; c += 2) begin
                    b = ch * 16 + r * 4 + c;
                    rq.push_back(b);
                    rq.push_back(b + 1);
                    rq.push_back(b + 4);
                    rq.push_back(b + 5);
                    e = (k < fix.size()) ? fix[k] : pool(b, relu);
                    wq.push_back('{addr: ch * 4 + (r / 2) * 2 + c / 2, data: e});
                    k++;
                end
            end
        end
        fix.delete();
    endtask

    // Output monitor: read/write scoreboards, stall stability, done pulse count.
    always @(negedge clk) begin
        if (rd_en) begin
            obs_rd.push_back(int'(rd_addr));
            if (rq.size() == 0) chk("rd_extra", int'(rd_addr), -1);
            else chk("rd_addr", int'(rd_addr), rq.pop_front());
        end
        if (wr_en) chk("rd_during_wr", int'(rd_en), 0);
        if (hold_prev) begin
            chk("stall_wr_en", int'(wr_en), 1);
            chk("stall_wr_addr", int'(wr_addr), prev_addr);
            chk("stall_wr_data", int'($signed(wr_data)), prev_data);
        end
        if (wr_en && wr_ready) begin
            obs_wr.push_back(int'(wr_addr));
            if (wq.size() == 0) begin
                chk("wr_extra", int'(wr_addr), -1);
            end else begin
                wcur = wq.pop_front();
                chk("wr_addr", int'(wr_addr), wcur.addr);
                chk("wr_data", int'($signed(wr_data)), wcur.data);
            end
        end
        hold_prev = wr_en && !wr_ready;
        prev_addr = int'(wr_addr);
        prev_data = int'($signed(wr_data));
        if (done) done_cnt++;
    end

    task automatic do_run(input logic relu, input int stall, input bit repulse);
        int t0;
        int snap;
        bit seen;
        load_exp(relu);
        snap = done_cnt;
        @(negedge clk);
        start   = 1'b1;
        relu_en = relu;
        t0      = cyc;
        @(negedge clk);
        start = 1'b0;
        if (stall > 0) begin
            seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(posedge clk);
                #1;
                seen = wr_en;
            end
            chk("stall_wr_seen", int'(seen), 1);
            wr_ready = 1'b0;
            repeat (stall) begin
                @(posedge clk);
                #1;
            end
            wr_ready = 1'b1;
        end
        if (repulse) begin
            repeat (10) @(negedge clk);
            chk("busy_mid", int'(busy), 1);
            start   = 1'b1;
            relu_en = ~relu;
            @(negedge clk);
            start = 1'b0;
        end
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            seen = done;
        end
        chk("done_seen", int'(seen), 1);
        chk("run_cycles", cyc - t0 - 1, 48 + stall);
        if (repulse) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("done_one_cycle", int'(done), 0);
        chk("idle_busy", int'(busy), 0);
        @(negedge clk);
        chk("idle_busy2", int'(busy), 0);
        chk("done_count", done_cnt - snap, 1);
        chk("wq_empty", wq.size(), 0);
        chk("rq_empty", rq.size(), 0);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_rd_en"}, int'(rd_en), 0);
        chk({tag, "_wr_en"}, int'(wr_en), 0);
        chk({tag, "_rd_addr"}, int'(rd_addr), 0);
        chk({tag, "_wr_addr"}, int'(wr_addr), 0);
        chk({tag, "_wr_data"}, int'(wr_data), 0);
    endtask

    initial begin
        bit seen;
        vecs[0]  = '{1'b1, -5, -3, -9, -1, 0};
        vecs[1]  = '{1'b0, -5, -3, -9, -1, -1};
        vecs[2]  = '{1'b0, 0, 1, 4, 5, 5};
        vecs[3]  = '{1'b0, 100, -200, 50, 99, 100};
        vecs[4]  = '{1'b1, -2097152, 2097151, 0, -1, 2097151};
        vecs[5]  = '{1'b0, -2097152, -2097151, -2097152, -2097150, -2097150};
        vecs[6]  = '{1'b0, 7, 7, 7, 7, 7};
        vecs[7]  = '{1'b1, -8, -9, -10, -8, 0};
        vecs[8]  = '{1'b0, -7, -9, -10, -8, -7};
        vecs[9]  = '{1'b1, 0, -1, -1, -1, 0};
        vecs[10] = '{1'b0, 1, 2, 30, 3, 30};

        set_base();
        repeat (3) @(negedge clk);
        chk_zero_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Row-major 0..15 map, ReLU on: known pooled values, then channel 1 at its offsets.
        fix = '{5, 7, 13, 15};
        obs_rd.delete();
        obs_wr.delete();
        do_run(1'b1, 0, 1'b0);
        chk("ch1_first_rd", (obs_rd.size() > 16) ? obs_rd[16] : -1, 16);
        chk("ch1_first_wr", (obs_wr.size() > 4) ? obs_wr[4] : -1, 4);

        // Write back-pressure on the first window.
        do_run(1'b1, 3, 1'b0);

        // start re-pulsed mid-run and in the DONE cycle.
        do_run(1'b0, 0, 1'b1);

        // Reset in RD2 of the third window, then a clean run.
        load_exp(1'b1);
        @(negedge clk);
        start   = 1'b1;
        relu_en = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = rd_en && (rd_addr == AWT'(12));
        end
        chk("rst_point_found", int'(seen), 1);
        rst = 1'b1;
        @(negedge clk);
        chk_zero_outputs("midrst");
        rst = 1'b0;
        wq.delete();
        rq.delete();
        @(negedge clk);
        chk("post_rst_idle", int'(busy), 0);
        do_run(1'b1, 0, 1'b0);

        // Window table: values placed in the first window of channel 0.
        for (int v = 0; v < 11; v++) begin
            set_base();
            img[0] = vecs[v].w0;
            img[1] = vecs[v].w1;
            img[4] = vecs[v].w2;
            img[5] = vecs[v].w3;
            fix = '{vecs[v].exp};
            do_run(vecs[v].relu, 0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pool_relu_ctrl.md
POOL_RELU_CTRL -- requirements
Module: pool_relu_ctrl

Interface
REQ-001 SHALL have parameter FM_W, default 24, meaning input feature-map width in pixels; must be even.
REQ-002 SHALL have parameter FM_H, default 24, meaning input feature-map height in pixels; must be even.
REQ-003 SHALL have parameter NCH, default 4, meaning number of channels processed per run.
REQ-004 SHALL have parameter AW, default 16, meaning read/write address width.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1, meaning reset; synchronous, active-high.
REQ-007 SHALL have port start, input, 1, meaning a one-cycle pulse that begins a run.
REQ-008 SHALL have port relu_en, input, 1, meaning apply ReLU when 1, bypass when 0; sampled on the start cycle.
REQ-009 SHALL have port busy, output, 1, meaning a run is in progress.
REQ-010 SHALL have port done, output, 1, meaning a one-cycle pulse after the last write is accepted.
REQ-011 SHALL have port rd_en, output, 1, meaning input-buffer read strobe.
REQ-012 SHALL have port rd_addr, output, AW, meaning input-buffer read address.
REQ-013 SHALL have port rd_data, input, DATSIZE (22), meaning signed read data, valid exactly 1 cycle after rd_en.
REQ-014 SHALL have port wr_en, output, 1, meaning output-buffer write request.
REQ-015 SHALL have port wr_addr, output, AW, meaning output-buffer write address.
REQ-016 SHALL have port wr_data, output, DATSIZE, meaning signed pooled result.
REQ-017 SHALL have port wr_ready, input, 1, meaning output buffer accepts the write; a write completes on a cycle with wr_en && wr_ready.

Function
REQ-018 SHALL implement FSM states IDLE, RD0, RD1, RD2, RD3, CAP, WR, DONE.
REQ-019 IDLE->RD0 SHALL occur on start=1; start SHALL be ignored in all other states.
REQ-020 RD0..RD3 SHALL assert rd_en, one cycle each, at in-addresses (r,c), (r,c+1), (r+1,c), (r+1,c+1); in-addr = ch*FM_H*FM_W + r*FM_W + c, truncated to AW.
REQ-021 rd_data SHALL be captured into window register k on the cycle after RDk; capture of k=3 occurs in CAP; rd_en=0 in CAP.
REQ-022 wr_data SHALL be the signed maximum of the four captured values, followed by ReLU (sign bit set -> 0) when the latched relu_en=1; on ties, either equal value is acceptable.
REQ-023 WR SHALL hold wr_en=1 with stable wr_addr/wr_data until wr_ready=1; out-addr = ch*(FM_H/2)*(FM_W/2) + (r/2)*(FM_W/2) + c/2.
REQ-024 On write accept, c SHALL advance by 2; at c=FM_W-2 it wraps to 0 and r advances by 2; at r=FM_H-2 r wraps to 0 and ch increments; after the last window of ch=NCH-1 the FSM enters DONE, otherwise RD0.
REQ-025 Each window SHALL take exactly 6 cycles with wr_ready held at 1; a full run SHALL take NCH*(FM_H/2)*(FM_W/2)*6 cycles from start to DONE.
REQ-026 DONE SHALL pulse done=1 for one cycle, then return to IDLE.
REQ-027 busy SHALL be 1 in every state except IDLE.
REQ-028 A start arriving in the DONE cycle SHALL be ignored.

Reset
REQ-029 rst=1 SHALL, on the next edge, force state to IDLE and clear ch, r, c, and the window registers from any state, including mid-window and mid-WR stall.
REQ-030 Reset values: busy=0, done=0, rd_en=0, wr_en=0, rd_addr=0, wr_addr=0, wr_data=0.

Structure
REQ-031 DATSIZE (22), AW default, and state encodings SHALL reside in the shared nn definitions include/package.
REQ-032 The datapath SHALL instantiate the existing max_4 and relu modules, with a mux for relu_en bypass; no other sub-module.

Verification
REQ-033 4x4x1 map, values 0..15 row-major, relu_en=1 -> writes 5,7,13,15 at addresses 0,1,2,3; done at cycle 24 after start.
REQ-034 Window {-5,-3,-9,-1}, relu_en=1 -> wr_data=0; same window with relu_en=0 -> wr_data=-1.
REQ-035 wr_ready=0 for 3 cycles during the first WR -> wr_en, wr_addr and wr_data held stable; run takes 3 extra cycles; no read issued during the stall.
REQ-036 start re-pulsed while busy -> no restart; addresses continue in sequence; exactly one done pulse.
REQ-037 rst asserted in RD2 of window 2 -> next cycle IDLE, busy=0, rd_en=0, wr_en=0; a new start produces the full correct sequence from address 0.
REQ-038 NCH=2, 4x4 -> second channel reads begin at in-addr 16 and writes at out-addr 4.
